// File: rtl/riscv_v_pkg.sv
// Shared definitions for the RISC-V vector CSR controller: CSR addresses,
// vtype field encodings, VS status encodings and reset values.
package riscv_v_pkg;

    // Vector CSR addresses
    localparam logic [11:0] CSR_VSTART = 12'h008;
    localparam logic [11:0] CSR_VXSAT  = 12'h009;
    localparam logic [11:0] CSR_VXRM   = 12'h00A;
    localparam logic [11:0] CSR_VCSR   = 12'h00F;
    localparam logic [11:0] CSR_VL     = 12'hC20;
    localparam logic [11:0] CSR_VTYPE  = 12'hC21;
    localparam logic [11:0] CSR_VLENB  = 12'hC22;

    // vsew encodings; 3'b1xx are reserved
    typedef enum logic [2:0] {
        VSEW_8  = 3'd0,
        VSEW_16 = 3'd1,
        VSEW_32 = 3'd2,
        VSEW_64 = 3'd3
    } vsew_e;

    // vlmul encodings; 3'b100 is reserved
    typedef enum logic [2:0] {
        LMUL_1    = 3'b000,
        LMUL_2    = 3'b001,
        LMUL_4    = 3'b010,
        LMUL_8    = 3'b011,
        LMUL_RSVD = 3'b100,
        LMUL_F8   = 3'b101,
        LMUL_F4   = 3'b110,
        LMUL_F2   = 3'b111
    } vlmul_e;

    // Low byte of vtype; the upper XLEN-8 bits are vill plus reserved zeros
    typedef struct packed {
        logic       vma;
        logic       vta;
        logic [2:0] vsew;
        logic [2:0] vlmul;
    } vtype_lo_t;

    // VS status field encodings
    localparam logic [1:0] VS_OFF     = 2'd0;
    localparam logic [1:0] VS_INITIAL = 2'd1;
    localparam logic [1:0] VS_CLEAN   = 2'd2;
    localparam logic [1:0] VS_DIRTY   = 2'd3;

    // Reset values for the fixed-width CSR fields
    localparam logic [1:0] VXRM_RST  = 2'd0;
    localparam logic       VXSAT_RST = 1'b0;
    localparam logic [1:0] VS_RST    = VS_OFF;

    // True for the writable vector CSRs
    function automatic logic is_rw_csr(input logic [11:0] addr);
        return (addr == CSR_VSTART) || (addr == CSR_VXSAT) ||
               (addr == CSR_VXRM)   || (addr == CSR_VCSR);
    endfunction

endpackage

// File: rtl/riscv_v_vlmax_calc.sv
// Combinational vtype decoder: derives VLMAX and the vill flag from a raw
// vtype operand for the given VLEN/ELEN.
module riscv_v_vlmax_calc
    import riscv_v_pkg::*;
#(
    parameter int unsigned VLEN = 128,
    parameter int unsigned ELEN = 64,
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]        vtype,
    output logic [$clog2(VLEN):0]  vlmax,
    output logic                   vill
);

    localparam int unsigned CW = $clog2(VLEN) + 1;

    vtype_lo_t   f;
    logic [31:0] per_reg;
    logic [31:0] sew_bits;
    logic [31:0] elen_frac;
    logic [31:0] vlmax_full;
    logic [1:0]  frac_n;
    logic        frac;

    assign f = vtype[7:0];

    // Decode SEW/LMUL, check legality and scale VLEN/SEW by LMUL
    always_comb begin
        per_reg   = 32'(VLEN) >> ({1'b0, f.vsew[1:0]} + 3'd3);
        sew_bits  = 32'd8 << f.vsew[1:0];
        frac      = f.vlmul[2] && (f.vlmul != LMUL_RSVD);
        // 111 -> 1, 110 -> 2, 101 -> 3 (LMUL = 1/2^n)
        frac_n    = (~f.vlmul[1:0]) + 2'd1;
        elen_frac = 32'(ELEN) >> frac_n;

        vill = 1'b0;
        if (f.vsew[2])                    vill = 1'b1;
        if (f.vlmul == LMUL_RSVD)         vill = 1'b1;
        if (sew_bits > 32'(ELEN))         vill = 1'b1;
        if (frac && sew_bits > elen_frac) vill = 1'b1;
        if (|vtype[XLEN-2:8])             vill = 1'b1;

        if (frac) vlmax_full = per_reg >> frac_n;
        else      vlmax_full = per_reg << f.vlmul[1:0];

        vlmax = vill ? '0 : vlmax_full[CW-1:0];
    end

    logic unused_bits;
    assign unused_bits = ^{vtype[XLEN-1], f.vma, f.vta, vlmax_full[31:CW]};

endmodule

// File: rtl/riscv_v_csr_ctrl.sv
// Vector CSR controller: holds vtype/vl/vstart/vxrm/vxsat/VS state, executes
// vsetvl/vsetvli/vsetivli through a three-state handshaked pipeline and
// services CSR reads/writes from the decode stage.
module riscv_v_csr_ctrl
    import riscv_v_pkg::*;
#(
    parameter int unsigned VLEN = 128,
    parameter int unsigned ELEN = 64,
    parameter int unsigned XLEN = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vset_valid,
    output logic                      vset_ready,
    input  logic [XLEN-1:0]           vset_avl,
    input  logic [XLEN-1:0]           vset_vtype,
    input  logic                      vset_rs1_x0,
    input  logic                      vset_rd_x0,
    output logic                      vset_resp_valid,
    output logic [XLEN-1:0]           vset_resp_vl,
    input  logic                      csr_wr_en,
    input  logic [11:0]               csr_wr_addr,
    input  logic [XLEN-1:0]           csr_wdata,
    input  logic [11:0]               csr_rd_addr,
    output logic [XLEN-1:0]           csr_rdata,
    output logic                      csr_illegal,
    input  logic                      elem_commit,
    input  logic                      instr_done,
    input  logic                      sat_set,
    output logic [XLEN-1:0]           vtype_out,
    output logic [$clog2(VLEN):0]     vl_out,
    output logic [$clog2(VLEN)-1:0]   vstart_out,
    output logic [1:0]                vxrm_out,
    output logic [1:0]                vs_out
);

    localparam int unsigned CW = $clog2(VLEN) + 1;
    localparam int unsigned SW = $clog2(VLEN);
    localparam logic [XLEN-1:0] VTYPE_VILL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_COMMIT
    } state_e;

    state_e          state;
    logic            ready_q;
    logic            resp_valid_q;
    logic [XLEN-1:0] resp_vl_q;
    logic [XLEN-1:0] avl_q;
    logic [XLEN-1:0] vtype_in_q;
    logic            rs1_x0_q;
    logic            rd_x0_q;
    logic [XLEN-1:0] vtype_q;
    logic [CW-1:0]   vl_q;
    logic [SW-1:0]   vstart_q;
    logic [1:0]      vxrm_q;
    logic            vxsat_q;
    logic [1:0]      vs_q;
    logic            illegal_q;

    logic [CW-1:0]   calc_vlmax;
    logic            calc_vill;
    logic [CW-1:0]   new_vl;
    logic            new_vill;
    logic            vset_upd;
    logic            wr_legal;
    logic            wr_bad;

    riscv_v_vlmax_calc #(
        .VLEN (VLEN),
        .ELEN (ELEN),
        .XLEN (XLEN)
    ) u_vlmax_calc (
        .vtype (vtype_in_q),
        .vlmax (calc_vlmax),
        .vill  (calc_vill)
    );

    // Resolve the new vl (and late vill for the keep-vl form) from captured operands
    always_comb begin
        new_vill = calc_vill;
        new_vl   = vl_q;
        if (!calc_vill) begin
            if (!rs1_x0_q)
                new_vl = (avl_q < XLEN'(calc_vlmax)) ? avl_q[CW-1:0] : calc_vlmax;
            else if (!rd_x0_q)
                new_vl = calc_vlmax;
            else if (calc_vlmax < vl_q)
                new_vill = 1'b1;
        end
        if (new_vill) new_vl = '0;
    end

    assign vset_upd = (state == S_CALC);
    assign wr_legal = csr_wr_en &&  is_rw_csr(csr_wr_addr);
    assign wr_bad   = csr_wr_en && !is_rw_csr(csr_wr_addr);

    // vset FSM; vtype/vl are written on the CALC->COMMIT edge so they are
    // visible together with the response pulse during COMMIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_vl_q    <= '0;
            avl_q        <= '0;
            vtype_in_q   <= '0;
            rs1_x0_q     <= 1'b0;
            rd_x0_q      <= 1'b0;
            vtype_q      <= VTYPE_VILL;
            vl_q         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (vset_valid && ready_q) begin
                        avl_q      <= vset_avl;
                        vtype_in_q <= vset_vtype;
                        rs1_x0_q   <= vset_rs1_x0;
                        rd_x0_q    <= vset_rd_x0;
                        ready_q    <= 1'b0;
                        state      <= S_CALC;
                    end
                end
                S_CALC: begin
                    vtype_q      <= new_vill ? VTYPE_VILL : {1'b0, vtype_in_q[XLEN-2:0]};
                    vl_q         <= new_vl;
                    resp_vl_q    <= XLEN'(new_vl);
                    resp_valid_q <= 1'b1;
                    state        <= S_COMMIT;
                end
                S_COMMIT: begin
                    resp_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                    state        <= S_IDLE;
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

    // CSR state: vstart tracking, sticky vxsat, vxrm, VS dirty and illegal pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vstart_q  <= '0;
            vxrm_q    <= VXRM_RST;
            vxsat_q   <= VXSAT_RST;
            vs_q      <= VS_RST;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= wr_bad;

            if (wr_legal && csr_wr_addr == CSR_VSTART) vstart_q <= csr_wdata[SW-1:0];
            else if (vset_upd || instr_done)           vstart_q <= '0;
            else if (elem_commit)                      vstart_q <= vstart_q + 1'b1;

            if (wr_legal && (csr_wr_addr == CSR_VXSAT || csr_wr_addr == CSR_VCSR))
                vxsat_q <= csr_wdata[0] | sat_set;
            else if (sat_set)
                vxsat_q <= 1'b1;

            if (wr_legal && csr_wr_addr == CSR_VXRM)      vxrm_q <= csr_wdata[1:0];
            else if (wr_legal && csr_wr_addr == CSR_VCSR) vxrm_q <= csr_wdata[2:1];

            if (wr_legal || vset_upd) vs_q <= VS_DIRTY;
        end
    end

    // Combinational CSR read port
    always_comb begin
        csr_rdata = '0;
        case (csr_rd_addr)
            CSR_VSTART: csr_rdata = XLEN'(vstart_q);
            CSR_VXSAT:  csr_rdata = XLEN'(vxsat_q);
            CSR_VXRM:   csr_rdata = XLEN'(vxrm_q);
            CSR_VCSR:   csr_rdata = XLEN'({vxrm_q, vxsat_q});
            CSR_VL:     csr_rdata = XLEN'(vl_q);
            CSR_VTYPE:  csr_rdata = vtype_q;
            CSR_VLENB:  csr_rdata = XLEN'(VLEN / 8);
            default:    csr_rdata = '0;
        endcase
    end

    assign vset_ready      = ready_q;
    assign vset_resp_valid = resp_valid_q;
    assign vset_resp_vl    = resp_vl_q;
    assign csr_illegal     = illegal_q;
    assign vtype_out       = vtype_q;
    assign vl_out          = vl_q;
    assign vstart_out      = vstart_q;
    assign vxrm_out        = vxrm_q;
    assign vs_out          = vs_q;

    logic unused_wdata;
    assign unused_wdata = ^csr_wdata[XLEN-1:SW];

endmodule
